// File: rtl/branch_pred_ctrl_pkg.sv
// Shared definitions for the branch predictor: resolved-branch type codes,
// 2-bit counter states and the saturating counter helpers.
package branch_pred_ctrl_pkg;

    localparam logic [1:0] TYPE_B    = 2'b00;
    localparam logic [1:0] TYPE_JR   = 2'b01;
    localparam logic [1:0] TYPE_BEQZ = 2'b10;
    localparam logic [1:0] TYPE_BNEZ = 2'b11;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    function automatic logic [1:0] cnt_inc(input logic [1:0] c);
        return (c == CNT_ST) ? CNT_ST : c + 2'd1;
    endfunction

    function automatic logic [1:0] cnt_dec(input logic [1:0] c);
        return (c == CNT_SNT) ? CNT_SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/branch_pred_ctrl_btb_table.sv
// Direct-mapped BTB storage: valid/tag/target/counter per entry.
// The write port exposes the current entry at wr_idx so the caller can do read-modify-write.
module btb_table
    import branch_pred_ctrl_pkg::*;
#(
    parameter int         IDX_W    = 3,
    parameter logic [1:0] CNT_INIT = CNT_WNT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic               rd_valid,
    output logic [15-IDX_W:0]  rd_tag,
    output logic [15:0]        rd_tgt,
    output logic [1:0]         rd_cnt,
    input  logic [IDX_W-1:0]   wr_idx,
    output logic               wr_cur_valid,
    output logic [15-IDX_W:0]  wr_cur_tag,
    output logic [15:0]        wr_cur_tgt,
    output logic [1:0]         wr_cur_cnt,
    input  logic               wr_en,
    input  logic [15-IDX_W:0]  wr_tag,
    input  logic [15:0]        wr_tgt,
    input  logic [1:0]         wr_cnt
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = 16 - IDX_W;

    logic [ENTRIES-1:0]            valid_q, valid_d;
    logic [ENTRIES-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [ENTRIES-1:0][15:0]      tgt_q, tgt_d;
    logic [ENTRIES-1:0][1:0]       cnt_q, cnt_d;

    assign rd_valid     = valid_q[rd_idx];
    assign rd_tag       = tag_q[rd_idx];
    assign rd_tgt       = tgt_q[rd_idx];
    assign rd_cnt       = cnt_q[rd_idx];
    assign wr_cur_valid = valid_q[wr_idx];
    assign wr_cur_tag   = tag_q[wr_idx];
    assign wr_cur_tgt   = tgt_q[wr_idx];
    assign wr_cur_cnt   = cnt_q[wr_idx];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
            tag_d[wr_idx]   = wr_tag;
            tgt_d[wr_idx]   = wr_tgt;
            cnt_d[wr_idx]   = wr_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            tag_q   <= '0;
            tgt_q   <= '0;
            cnt_q   <= {ENTRIES{CNT_INIT}};
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/branch_pred_ctrl.sv
// Branch predictor and redirect controller: IF-stage BTB lookup, ID-stage
// outcome/mispredict detection, redirect generation and BTB training.
module branch_pred_ctrl
    import branch_pred_ctrl_pkg::*;
#(
    parameter int         IDX_W    = 3,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] if_pc,
    output logic        pred_taken,
    output logic [15:0] pred_target,
    input  logic        res_valid,
    input  logic [15:0] res_pc,
    input  logic [1:0]  res_type,
    input  logic        res_zero,
    input  logic [15:0] res_target,
    input  logic        res_pred_taken,
    input  logic [15:0] res_pred_target,
    output logic        flush,
    output logic [15:0] redirect_pc,
    output logic [15:0] mispred_cnt
);
    logic              rd_valid;
    logic [15-IDX_W:0] rd_tag;
    logic [15:0]       rd_tgt;
    logic [1:0]        rd_cnt;
    logic              cur_valid;
    logic [15-IDX_W:0] cur_tag;
    logic [15:0]       cur_tgt;
    logic [1:0]        cur_cnt;
    logic              wr_en;
    logic [15:0]       wr_tgt;
    logic [1:0]        wr_cnt;

    logic        hit, taken, mispred, res_hit;
    logic [15:0] mispred_cnt_q, mispred_cnt_d;

    btb_table #(.IDX_W(IDX_W), .CNT_INIT(CNT_INIT)) u_btb (
        .clk          (clk),
        .rst          (rst),
        .rd_idx       (if_pc[IDX_W-1:0]),
        .rd_valid     (rd_valid),
        .rd_tag       (rd_tag),
        .rd_tgt       (rd_tgt),
        .rd_cnt       (rd_cnt),
        .wr_idx       (res_pc[IDX_W-1:0]),
        .wr_cur_valid (cur_valid),
        .wr_cur_tag   (cur_tag),
        .wr_cur_tgt   (cur_tgt),
        .wr_cur_cnt   (cur_cnt),
        .wr_en        (wr_en),
        .wr_tag       (res_pc[15:IDX_W]),
        .wr_tgt       (wr_tgt),
        .wr_cnt       (wr_cnt)
    );

    assign hit         = rd_valid && (rd_tag == if_pc[15:IDX_W]);
    assign pred_taken  = hit && rd_cnt[1];
    assign pred_target = pred_taken ? rd_tgt : if_pc + 16'd1;

    always_comb begin
        unique case (res_type)
            TYPE_B, TYPE_JR: taken = 1'b1;
            TYPE_BEQZ:       taken = res_zero;
            default:         taken = !res_zero;
        endcase
    end

    assign mispred     = res_valid && ((taken != res_pred_taken) ||
                                       (taken && (res_target != res_pred_target)));
    assign flush       = mispred;
    assign redirect_pc = !res_valid ? 16'h0000 : (taken ? res_target : res_pc + 16'd1);

    // JR targets come from a register, so they never touch the table.
    assign res_hit = cur_valid && (cur_tag == res_pc[15:IDX_W]);

    always_comb begin
        wr_en  = 1'b0;
        wr_tgt = cur_tgt;
        wr_cnt = cur_cnt;
        if (res_valid && (res_type != TYPE_JR)) begin
            if (res_hit) begin
                wr_en = 1'b1;
                if (taken) begin
                    wr_cnt = cnt_inc(cur_cnt);
                    wr_tgt = res_target;
                end else begin
                    wr_cnt = cnt_dec(cur_cnt);
                end
            end else if (taken) begin
                wr_en  = 1'b1;
                wr_tgt = res_target;
                wr_cnt = (res_type == TYPE_B) ? CNT_ST : CNT_WT;
            end
        end
    end

    always_comb begin
        mispred_cnt_d = mispred_cnt_q;
        if (mispred && (mispred_cnt_q != 16'hFFFF))
            mispred_cnt_d = mispred_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mispred_cnt_q <= '0;
        else     mispred_cnt_q <= mispred_cnt_d;
    end

    assign mispred_cnt = mispred_cnt_q;

endmodule
